rv32c_fetch_aligner: RTL and testbench
======================================

# rv32c_fetch_aligner

Halfword realignment buffer between the instruction fetch port and the RV32C decompressor. It accepts word-aligned 32-bit fetch data and reassembles the instruction stream into whole instructions. Each instruction is 16-bit (compressed) or 32-bit and may straddle a fetch-word boundary. It presents one instruction per cycle with its PC: the head halfword goes to the decompressor's `inst16` input, and the full 32-bit form goes to the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0200, PC of the first instruction after reset. Bit 0 must be 0.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- redirect  in  1  branch/jump/exception redirect, one-cycle pulse
- redirect_pc  in  32  new PC; bit 0 ignored (treated as 0)
- fdata  in  32  fetch word, little-endian halfwords; [15:0] is the lower address
- fdata_valid  in  1  fdata holds the next sequential fetch word
- fdata_ready  out  1  aligner can accept a word this cycle
- inst  out  32  compressed: {16'h0, hw0}; full: {hw1, hw0}
- inst16  out  16  head halfword hw0, to the decompressor
- is_compressed  out  1  hw0[1:0] != 2'b11
- inst_pc  out  32  PC of the presented instruction
- inst_valid  out  1  a complete instruction is presented
- inst_ready  in  1  consumer takes the instruction this cycle

## Operation
- State:
  - halfword queue q[0..3], 16 bits each; head is q[0], kept in shift order.
  - count, 0..4.
  - pc register, 32 bits.
  - drop_low flag.
- Push:
  - A push occurs when fdata_valid && fdata_ready.
  - If drop_low=0: fdata[15:0] is enqueued, then fdata[31:16]; count += 2.
  - If drop_low=1: only fdata[31:16] is enqueued; count += 1; drop_low clears.
- Output:
  - head_c = q[0][1:0] != 2'b11.
  - inst_valid = (count >= 1 && head_c) || count >= 2.
- Pop:
  - A pop occurs when inst_valid && inst_ready.
  - It removes 1 halfword if is_compressed, else 2. pc advances by 2 or 4 respectively, with 32-bit wrap.
- fdata_ready = (count <= 2) && !redirect. It depends on registered state and redirect only, never on inst_ready.
- Push and pop in the same cycle are allowed.
  - Next count = count − popped + pushed. This is always ≤ 4.
  - Pushed halfwords land after the remaining entries.
- Redirect has absolute priority in its cycle:
  - count ← 0 and pc ← {redirect_pc[31:1], 1'b0}.
  - drop_low ← redirect_pc[1].
  - Any pop that cycle is ignored, and no push occurs (fdata_ready is forced to 0).
- Fetch-side contract: the first word offered after a redirect is the word containing redirect_pc. The fetch unit squashes stale in-flight words before the redirect completes.
- Queue entries at index ≥ count are don't-care. Outputs derived from them are don't-care while inst_valid=0.

## Timing
- Reset (nRST low, asynchronous):
  - count=0, pc=RESET_PC, drop_low=RESET_PC[1], queue cleared to 0.
  - Resulting outputs: inst_valid=0, fdata_ready=1, inst_pc=RESET_PC, inst=0, inst16=0, is_compressed=1.
- Outputs are combinational from registered state only, except fdata_ready, which also depends on redirect.
- No bypass: a word pushed at edge N is visible on inst at the earliest from cycle N+1.
- Maximum throughput is one instruction per cycle with a sustained one word per cycle.
- A 32-bit instruction that straddles a word boundary is valid one cycle after the second word's push.
- After a redirect at edge N: inst_valid=0 in cycle N+1; fdata_ready=1 in cycle N+1.
- Reset asserted mid-operation discards the queue immediately. The same word must be re-offered after reset.

## Test plan
1. Reset: assert nRST=0 mid-stream.
   - Required: inst_valid=0, fdata_ready=1, inst_pc=0x200, count empty.
   - After release with no fdata_valid, the outputs hold those values.
2. Aligned 32-bit: push 0x00A00513.
   - Next cycle: inst=0x00A00513, is_compressed=0, inst_pc=0x200.
   - Pop → inst_pc=0x204, inst_valid=0.
3. Two compressed: push 0x45014505.
   - First: inst16=0x4505, inst=0x00004505, pc=0x200.
   - Next: inst16=0x4501, pc=0x202.
   - Then inst_valid=0.
4. Straddle: push 0x05134505, then 0x123400A0.
   - 0x4505 at pc 0x200.
   - inst_valid=0 until the second word is in.
   - Then inst=0x00A00513 at 0x202.
   - Then inst16=0x1234, is_compressed=1, at 0x206.
5. Redirect to 0x302: pulse redirect with inst_valid=1 and fdata_valid=1.
   - Redirect cycle: no pop and fdata_ready=0.
   - Next push 0x45010000 yields only 0x4501 at pc 0x302.
6. Backpressure: inst_ready=0 with words offered every cycle.
   - Two words accepted, then fdata_ready=0 with count=4.
   - One cycle of inst_ready=1 on a 32-bit head gives fdata_ready=1 the next cycle. No data is lost or reordered.

Source files
------------

// File: rtl/rv32c_fetch_aligner_if.sv
// Fetch-side and decode-side handshake bundle of the RV32C fetch aligner.
// slave: aligner side (takes fetch words, presents instructions); master: the environment.
interface rv32c_fetch_aligner_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fdata;
  logic        fdata_valid;
  logic        fdata_ready;
  logic [31:0] inst;
  logic [15:0] inst16;
  logic        is_compressed;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  modport slave (
    input  redirect, redirect_pc,
    input  fdata, fdata_valid, inst_ready,
    output fdata_ready, inst, inst16,
    output is_compressed, inst_pc, inst_valid
  );

  modport master (
    output redirect, redirect_pc,
    output fdata, fdata_valid, inst_ready,
    input  fdata_ready, inst, inst16,
    input  is_compressed, inst_pc, inst_valid
  );
endinterface

// File: rtl/rv32c_fetch_aligner.sv
// Halfword realignment queue: word fetches in, one whole RV32/RV32C instruction out per cycle.
// Ports: CLK, nRST (async low), bus (slave modport: redirect, fetch word handshake, instruction handshake).
module rv32c_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input logic              CLK,
  input logic              nRST,
  rv32c_fetch_aligner_if.slave bus
);
  logic [15:0] q    [4];
  logic [15:0] sh   [4];
  logic [15:0] q_nx [4];
  logic [2:0]  count;
  logic [2:0]  count_nx;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [2:0]  keep;
  logic [31:0] pc;
  logic        drop_low;
  logic        head_c;
  logic        push;
  logic        pop;
  logic        unused_pc0;

  assign unused_pc0 = bus.redirect_pc[0];

  assign head_c = q[0][1:0] != 2'b11;

  assign bus.inst_valid =
    (count != 3'd0 && head_c) || count >= 3'd2;
  assign bus.fdata_ready =
    count <= 3'd2 && !bus.redirect;
  assign bus.is_compressed = head_c;
  assign bus.inst16 = q[0];
  assign bus.inst = head_c ?
    {16'h0, q[0]} : {q[1], q[0]};
  assign bus.inst_pc = pc;

  assign push = bus.fdata_valid && bus.fdata_ready;
  assign pop = bus.inst_valid && bus.inst_ready &&
    !bus.redirect;

  assign pop_n = !pop ? 3'd0 :
    head_c ? 3'd1 : 3'd2;
  assign push_n = !push ? 3'd0 :
    drop_low ? 3'd1 : 3'd2;
  assign keep = count - pop_n;
  assign count_nx = keep + push_n;

  // Shift out popped entries, then append the
  // pushed halfwords behind the survivors.
  always_comb begin
    sh = q;
    unique case (1'b1)
      pop_n == 3'd2:
        sh = '{q[2], q[3], 16'h0, 16'h0};
      pop_n == 3'd1:
        sh = '{q[1], q[2], q[3], 16'h0};
      default:
        sh = q;
    endcase
    for (int i = 0; i < 4; i++) begin
      q_nx[i] = sh[i];
      if (push) begin
        if (drop_low) begin
          if (keep == 3'(i))
            q_nx[i] = bus.fdata[31:16];
        end else begin
          if (keep == 3'(i))
            q_nx[i] = bus.fdata[15:0];
          if (keep + 3'd1 == 3'(i))
            q_nx[i] = bus.fdata[31:16];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count    <= 3'd0;
      pc       <= RESET_PC;
      drop_low <= RESET_PC[1];
      q        <= '{default: 16'h0};
    end else if (bus.redirect) begin
      count    <= 3'd0;
      pc       <= {bus.redirect_pc[31:1], 1'b0};
      drop_low <= bus.redirect_pc[1];
    end else begin
      count <= count_nx;
      q     <= q_nx;
      if (pop)
        pc <= pc + (head_c ? 32'd2 : 32'd4);
      if (push)
        drop_low <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rv32c_fetch_aligner.sv
// Randomized scoreboard bench for rv32c_fetch_aligner.
// Instruction stream is read from a halfword memory model; no DUT ports.
module tb_rv32c_fetch_aligner;
  localparam logic [31:0] BASE = 32'h0000_0200;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic CLK;
  logic nRST;
  rv32c_fetch_aligner_if bus();

  rv32c_fetch_aligner #(.RESET_PC(BASE)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] mem [1024];
  exp_t sbq[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  bit run = 0;
  logic [31:0] pc_m;
  logic [31:0] fa;
  int seg = 0;
  int stall = 0;

  function automatic int idx(input logic [31:0] a);
    return int'(((a - BASE) >> 1) & 32'h3FF);
  endfunction

  // Expected instruction sequence walking the memory from p0.
  function automatic void fill(input logic [31:0] p0);
    logic [31:0] p;
    logic [15:0] h;
    p = p0;
    sbq.delete();
    for (int k = 0; k < 100; k++) begin
      h = mem[idx(p)];
      if (h[1:0] != 2'b11) begin
        sbq.push_back('{{16'h0, h}, p});
        p = p + 32'd2;
      end else begin
        sbq.push_back('{{mem[idx(p + 32'd2)], h}, p});
        p = p + 32'd4;
      end
    end
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (run && nRST && bus.inst_valid &&
        bus.inst_ready && !bus.redirect) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty act=pop exp=none");
      end else begin
        e = sbq.pop_front();
        chk("inst", bus.inst, e.inst);
        chk("pop_pc", bus.inst_pc, e.pc);
        chk("inst16", 32'(bus.inst16),
            32'(e.inst[15:0]));
        chk("is_c", 32'(bus.is_compressed),
            32'(e.inst[1:0] != 2'b11));
      end
    end
  end

  task automatic idle_inputs();
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.fdata       = 32'h0;
    bus.fdata_valid = 1'b0;
    bus.inst_ready  = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus.fdata_ready), 32'd1);
    chk({tag, "_pc"}, bus.inst_pc, BASE);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    chk_reset_outs("rst");
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst16", 32'(bus.inst16), 32'h0);
    chk("rst_is_c", 32'(bus.is_compressed), 32'd1);
    pc_m = BASE;
    fa = BASE;
    seg = 0;
    stall = 0;
    fill(BASE);
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    chk_reset_outs("hold");
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    bit redir;
    bit fv;
    bit ir;
    bit ev;
    bit er;
    int d;
    int b;
    logic [31:0] rpc;
    logic [15:0] h;
    redir = (seg >= 80) || ($urandom % 40 == 0);
    seg = redir ? 0 : seg + 1;
    rpc = BASE + 32'(2 * $urandom_range(0, 800));
    rpc[0] = 1'($urandom % 2);
    if (stall > 0) begin
      ir = 1'b0;
      stall--;
    end else begin
      if ($urandom % 25 == 0)
        stall = 6;
      ir = ($urandom % 4) != 0;
    end
    fv = ($urandom % 5) != 0;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.fdata       = {mem[idx(fa) + 1], mem[idx(fa)]};
    bus.fdata_valid = fv;
    bus.inst_ready  = ir;
    @(negedge CLK);
    d = int'(fa - pc_m);
    b = d > 0 ? d / 2 : 0;
    h = mem[idx(pc_m)];
    ev = b >= 2 || (b >= 1 && h[1:0] != 2'b11);
    er = b <= 2 && !redir;
    chk("fdata_ready", 32'(bus.fdata_ready), 32'(er));
    chk("inst_valid", 32'(bus.inst_valid), 32'(ev));
    chk("inst_pc", bus.inst_pc, pc_m);
    if (redir) begin
      pc_m = {rpc[31:1], 1'b0};
      fa = {pc_m[31:2], 2'b00};
      fill(pc_m);
    end else begin
      if (fv && er)
        fa = fa + 32'd4;
      if (ev && ir)
        pc_m = pc_m + (h[1:0] != 2'b11 ?
                       32'd2 : 32'd4);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [15:0] h;
    logic [15:0] prog [8];
    prog = '{16'h0513, 16'h00A0, 16'h4505,
             16'h4501, 16'h4505, 16'h0513,
             16'h00A0, 16'h1234};
    for (int i = 0; i < 1024; i++) begin
      h = 16'($urandom);
      if ($urandom % 2 == 0)
        h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11)
        h[1:0] = 2'b01;
      mem[i] = h;
    end
    for (int i = 0; i < 8; i++)
      mem[i] = prog[i];
    nRST = 1'b0;
    idle_inputs();
    pc_m = BASE;
    fa = BASE;
    fill(BASE);
    @(posedge CLK);
    #1 run = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500)
        do_reset();
      step();
    end
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
